// File: rtl/bw_ctu_impctl_sscan_ctl.sv
// Shadow-scan sequencer for the impedance-control chain: snap, shift a code in
// while capturing the old one, optionally pulse update, then report the capture.
module bw_ctu_impctl_sscan_ctl #(
    parameter int CHAIN_LEN = 16,
    parameter int UPD_CYC   = 2
) (
    input  logic                 rclk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 upd_en,
    input  logic [CHAIN_LEN-1:0] wr_data,
    input  logic                 io_ctu_sscan_out,
    output logic                 ctu_global_snap,
    output logic                 ctu_io_sscan_se,
    output logic                 ctu_io_sscan_in,
    output logic                 ctu_io_sscan_update,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] rd_data
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [3:0]       UPD_LAST   = 4'(UPD_CYC - 1);

    typedef enum logic [2:0] {IDLE, SNAP, SHIFT, UPD, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     shift_cnt;
    logic [3:0]           upd_cnt;
    logic                 upd_lat;
    logic [CHAIN_LEN-1:0] wr_sr;
    logic [CHAIN_LEN-1:0] cap;
    logic [CHAIN_LEN-1:0] cap_nxt;
    logic                 snap_d;
    logic                 se_d;
    logic                 upd_d;
    logic                 busy_d;
    logic                 done_d;
    logic                 accept;

    assign accept = (state == IDLE) && start;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SNAP;
            SNAP:    state_nxt = SHIFT;
            SHIFT:   if (shift_cnt == SHIFT_LAST) state_nxt = upd_lat ? UPD : DONE;
            UPD:     if (upd_cnt == UPD_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so every pin is a flop.
    always_comb begin
        snap_d = (state_nxt == SNAP);
        se_d   = (state_nxt == SHIFT);
        upd_d  = (state_nxt == UPD);
        done_d = (state_nxt == DONE);
        busy_d = (state_nxt != IDLE);
    end

    // The last captured bit arrives on the same edge that enters DONE when update is skipped.
    always_comb begin
        cap_nxt = cap;
        if (state == SHIFT) cap_nxt = {cap[CHAIN_LEN-2:0], io_ctu_sscan_out};
    end

    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            shift_cnt           <= '0;
            upd_cnt             <= '0;
            upd_lat             <= 1'b0;
            ctu_global_snap     <= 1'b0;
            ctu_io_sscan_se     <= 1'b0;
            ctu_io_sscan_in     <= 1'b0;
            ctu_io_sscan_update <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            rd_data             <= '0;
        end else begin
            state               <= state_nxt;
            ctu_global_snap     <= snap_d;
            ctu_io_sscan_se     <= se_d;
            ctu_io_sscan_update <= upd_d;
            busy                <= busy_d;
            done                <= done_d;
            ctu_io_sscan_in     <= se_d ? wr_sr[CHAIN_LEN-1] : 1'b0;
            if (accept) upd_lat <= upd_en;
            if (state == SNAP)
                shift_cnt <= '0;
            else if ((state == SHIFT) && (shift_cnt != SHIFT_LAST))
                shift_cnt <= shift_cnt + 1'b1;
            if (state != UPD)
                upd_cnt <= '0;
            else if (upd_cnt != UPD_LAST)
                upd_cnt <= upd_cnt + 1'b1;
            if (done_d) rd_data <= cap_nxt;
        end
    end

    // Data path: load word on accept, then feed MSB first during SHIFT.
    always_ff @(posedge rclk) begin
        if (accept)
            wr_sr <= wr_data;
        else if (se_d)
            wr_sr <= {wr_sr[CHAIN_LEN-2:0], 1'b0};
        cap <= cap_nxt;
    end

endmodule
